// File: rtl/shift_norm_serial_if.sv
// ---------------------------------------------------------------------------
// shift_norm_serial_if
//
// Purpose:
//   Bundles the two valid/ready channels of shift_norm_serial:
//     - input channel  : a byte and its trailing-zero count
//     - output channel : odd part, exponent and status flags
//
// Signals:
//   in_valid   producer -> block   dat/cnt valid
//   in_ready   block -> producer   block can accept a new input
//   dat[DW]    producer -> block   byte to normalise
//   cnt[CW]    producer -> block   shift count from the trailing-zero counter
//   out_valid  block -> consumer   odd/exp/zero/err valid
//   out_ready  consumer -> block   consumer takes the result
//   odd[DW]    block -> consumer   dat >> exp
//   exp[CW]    block -> consumer   applied shift count, 0..8
//   zero       block -> consumer   input byte was 0x00
//   err        block -> consumer   count inconsistent with data
//
// Modports:
//   master : the environment (drives the input channel, consumes results)
//   slave  : the shift_norm_serial block itself
// ---------------------------------------------------------------------------
interface shift_norm_serial_if #(
  parameter int DW = 8,
  parameter int CW = 4
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dat;
  logic [CW-1:0] cnt;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] odd;
  logic [CW-1:0] exp;
  logic          zero;
  logic          err;

  modport master (
    output in_valid, dat, cnt, out_ready,
    input  in_ready, out_valid, odd, exp, zero, err
  );

  modport slave (
    input  in_valid, dat, cnt, out_ready,
    output in_ready, out_valid, odd, exp, zero, err
  );

endinterface : shift_norm_serial_if

// File: rtl/shift_norm_serial.sv
// ---------------------------------------------------------------------------
// shift_norm_serial
//
// Purpose:
//   Consumer of the combinational trailing-zero counter. Accepts a byte and
//   its shift count, shifts the byte right one bit per clock (zero fill)
//   min(cnt,8) times, then presents the odd part and exponent
//   (dat = odd << exp) on a valid/ready output until it is consumed.
//   Bridges the combinational count stage into clocked datapath logic.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   bus    slave modport of shift_norm_serial_if (input and output channels)
//
// Optional feature (compile-time macro):
//   CNT_CHECK_EN  defined   -> err flags a count inconsistent with the data:
//                               nonzero byte: a 1 bit was shifted out, or the
//                               result is still even;
//                               zero byte: cnt was not exactly 8.
//                 undefined -> err is tied to 0, cnt is trusted and no
//                               shifted-out tracking logic is built.
//
// Timing:
//   Accept at edge E0, out_valid rises after edge E(n+1), n = min(cnt,8)
//   (a zero byte always takes latency 1). in_ready is high only in IDLE, so
//   peak throughput is one result every n+3 cycles.
// ---------------------------------------------------------------------------
module shift_norm_serial #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic             clk,
  input  logic             reset,
  shift_norm_serial_if.slave bus
);

  // Largest meaningful shift: the whole byte width. Counts above it saturate.
  localparam logic [CW-1:0] MAX_SHIFT = CW'(DW);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [DW-1:0] r_sh;        // working shift register
  logic [CW-1:0] r_rem;       // shifts still to perform
  logic [DW-1:0] r_odd;       // result held on the output port
  logic [CW-1:0] r_exp;       // applied (saturated) shift count
  logic          r_zero;      // captured byte was 0x00

  logic          w_in_ready;
  logic          w_accept;
  logic          w_shift_done;
  logic          w_out_xfer;
  logic [CW-1:0] w_cnt_sat;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  // in_ready is gated by reset so no producer sees a ready block while the
  // reset is still asserted, even though the state register already reads IDLE.
  assign w_in_ready   = (r_state == S_IDLE) && !reset;
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_out_xfer   = (r_state == S_HOLD) && bus.out_ready;

  // A zero byte has no odd part to find, so it skips the shift loop entirely.
  assign w_shift_done = (r_state == S_SHIFT) && (r_zero || (r_rem == '0));

  assign w_cnt_sat    = (bus.cnt > MAX_SHIFT) ? MAX_SHIFT : bus.cnt;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every flop samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the next-state value gets a default before the case statement so
  // every path assigns it and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)     w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_shift_done) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_out_xfer)   w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  // Result registers are only written at acceptance and at the end of the
  // shift loop, so they stay frozen through HOLD and keep their last value
  // after the output transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh   <= '0;
      r_rem  <= '0;
      r_odd  <= '0;
      r_exp  <= '0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_sh   <= bus.dat;
      r_rem  <= w_cnt_sat;
      r_exp  <= w_cnt_sat;
      r_zero <= (bus.dat == '0);
    end else if (r_state == S_SHIFT) begin
      if (w_shift_done) begin
        r_odd <= r_sh;
      end else begin
        r_sh  <= r_sh >> 1;
        r_rem <= r_rem - 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Count consistency check
  // -------------------------------------------------------------------------
`ifdef CNT_CHECK_EN
  logic r_lost;         // a 1 bit has been shifted out of r_sh
  logic r_cnt_is_max;   // raw cnt was exactly DW at acceptance
  logic r_err;

  // The zero-byte rule looks at the raw count, so cnt==8 is captured before
  // saturation would hide counts 9..15.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lost       <= 1'b0;
      r_cnt_is_max <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_lost       <= 1'b0;
      r_cnt_is_max <= (bus.cnt == MAX_SHIFT);
      r_err        <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      if (w_shift_done) begin
        // A correct count leaves an odd value with nothing lost on the way.
        r_err <= r_zero ? !r_cnt_is_max : (r_lost || !r_sh[0]);
      end else begin
        r_lost <= r_lost || r_sh[0];
      end
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.odd       = r_odd;
  assign bus.exp       = r_exp;
  assign bus.zero      = r_zero;

endmodule : shift_norm_serial

// File: tb/tb_shift_norm_serial.sv
// ---------------------------------------------------------------------------
// tb_shift_norm_serial
//
// Self-checking bench for shift_norm_serial. Expected results come from a
// small arithmetic model of the normalisation rules (odd = dat >> min(cnt,8),
// latency min(cnt,8)+1 or 1 for a zero byte). Compile with +define+CNT_CHECK_EN
// to check the count-consistency flag as well.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_shift_norm_serial;

  logic clk;
  logic reset;

  int n_tests = 0;
  int n_fail  = 0;

  shift_norm_serial_if #(.DW(8), .CW(4)) bus ();

  shift_norm_serial #(.DW(8), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against any unbounded stall.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model ---------------------------------------------------------
  typedef struct {
    logic [7:0] odd;
    logic [3:0] exp;
    logic       zero;
    logic       err;
    int         lat;
  } result_t;

  function automatic result_t model(input logic [7:0] d, input logic [3:0] c);
    result_t r;
    int n;
    int lost;
    n      = (c > 8) ? 8 : int'(c);
    r.zero = (d == 8'h00);
    r.exp  = 4'(n);
    r.odd  = 8'(int'(d) / (1 << n));
    lost   = int'(d) % (1 << n);
    r.lat  = r.zero ? 1 : n + 1;
`ifdef CNT_CHECK_EN
    if (r.zero) r.err = (c != 4'd8);
    else        r.err = (lost != 0) || (r.odd % 2 == 0);
`else
    r.err = 1'b0;
`endif
    return r;
  endfunction

  // Full transaction: accept, measure latency, hold for hold_cyc cycles with
  // out_ready low (pulsing in_valid), then transfer.
  task automatic run_txn(input string tag, input logic [7:0] d, input logic [3:0] c,
                         input int hold_cyc);
    result_t m;
    bit got;
    int lat;
    m = model(d, c);
    check({tag, ".in_ready_idle"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.dat      = d;
    bus.cnt      = c;
    @(posedge clk); #1;
    // Inputs only matter at the accepting edge; scramble them afterwards.
    bus.in_valid = 1'b0;
    bus.dat      = 8'($urandom);
    bus.cnt      = 4'($urandom);
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      check({tag, ".in_ready_busy"}, bus.in_ready, 1'b0);
      if (bus.out_valid) begin
        got = 1'b1;
      end else begin
        @(posedge clk); #1;
        lat = k;
      end
    end
    if (!got) begin
      check({tag, ".timeout"}, 1'b0, 1'b1);
      return;
    end
    check({tag, ".latency"}, lat, m.lat);
    for (int h = 0; h <= hold_cyc; h++) begin
      check({tag, ".out_valid"}, bus.out_valid, 1'b1);
      check({tag, ".odd"},  bus.odd,  m.odd);
      check({tag, ".exp"},  bus.exp,  m.exp);
      check({tag, ".zero"}, bus.zero, m.zero);
      check({tag, ".err"},  bus.err,  m.err);
      if (h < hold_cyc) begin
        bus.in_valid = 1'b1;
        bus.dat      = 8'($urandom);
        bus.cnt      = 4'($urandom);
        @(posedge clk); #1;
        check({tag, ".in_ready_hold"}, bus.in_ready, 1'b0);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".out_valid_after"}, bus.out_valid, 1'b0);
    check({tag, ".in_ready_after"},  bus.in_ready,  1'b1);
    check({tag, ".odd_kept"},        bus.odd,       m.odd);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ".in_ready"},  bus.in_ready,  1'b0);
    check({tag, ".out_valid"}, bus.out_valid, 1'b0);
    check({tag, ".odd"},       bus.odd,       8'h00);
    check({tag, ".exp"},       bus.exp,       4'h0);
    check({tag, ".zero"},      bus.zero,      1'b0);
    check({tag, ".err"},       bus.err,       1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.dat       = 8'h00;
    bus.cnt       = 4'h0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    #2;
    check_outputs_zero("reset");
    #20;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_txn("d05_c0",  8'h05, 4'd0,  0);
    run_txn("d40_c6",  8'h40, 4'd6,  0);
    run_txn("d16_c1",  8'h16, 4'd1,  5);
    run_txn("d00_c8",  8'h00, 4'd8,  0);
    run_txn("d10_c12", 8'h10, 4'd12, 1);
    run_txn("d10_c2",  8'h10, 4'd2,  0);
    run_txn("d0A_c3",  8'h0A, 4'd3,  0);
    run_txn("d20_c5",  8'h20, 4'd5,  0);
    run_txn("d80_c7",  8'h80, 4'd7,  2);
    run_txn("dFF_c15", 8'hFF, 4'd15, 0);

    // Reset in the middle of a shift: accept at E0, reset after E2.
    bus.in_valid = 1'b1;
    bus.dat      = 8'h20;
    bus.cnt      = 4'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check({"post_reset", ".in_ready"}, bus.in_ready, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("post_reset.no_out_valid", bus.out_valid, 1'b0);
    end
    run_txn("d45_c0", 8'h45, 4'd0, 0);

    // Randomised traffic: mostly consistent counts, some deliberately wrong.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] d;
      logic [3:0] c;
      int tz;
      d = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      tz = 0;
      if (d == 8'h00) tz = 8;
      else while (((int'(d) >> tz) % 2) == 0) tz++;
      c = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'(tz);
      run_txn($sformatf("rnd%0d", i), d, c, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_shift_norm_serial
